// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Output reorder buffer for the 4-lane parallel FFT. Collects one frame of
//   bit-reversed samples from Sat1 into a ping-pong bank and replays it in
//   natural bin order, four consecutive bins per clock.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   fftIn0_up      lane 0 sample {real, imag}
//   fftIn0_down    lane 1 sample
//   fftIn1_up      lane 2 sample
//   fftIn1_down    lane 3 sample
//   in_enable      input beat valid
//   binOut0..3     bins 4m..4m+3 of the current output beat
//   o_enable       output beat valid
//   o_frame_start  high on output beat 0 of a frame
//   o_beat         output beat index m
module fft_out_reorder #(
  parameter int NBITS_out = 19,
  parameter int N         = 32,
  parameter int LOGN      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS_out-1:0] fftIn0_up,
  input  logic [2*NBITS_out-1:0] fftIn0_down,
  input  logic [2*NBITS_out-1:0] fftIn1_up,
  input  logic [2*NBITS_out-1:0] fftIn1_down,
  input  logic                   in_enable,
  output logic [2*NBITS_out-1:0] binOut0,
  output logic [2*NBITS_out-1:0] binOut1,
  output logic [2*NBITS_out-1:0] binOut2,
  output logic [2*NBITS_out-1:0] binOut3,
  output logic                   o_enable,
  output logic                   o_frame_start,
  output logic [LOGN-3:0]        o_beat
);

  localparam int              W    = 2 * NBITS_out;
  localparam logic [LOGN-3:0] LAST = (LOGN-2)'(N / 4 - 1);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  logic [W-1:0]    mem [2][N];
  logic [W-1:0]    lane [4];
  logic [LOGN-1:0] waddr [4];
  logic [LOGN-1:0] raddr [4];
  logic [W-1:0]    rd_data [4];

  logic [LOGN-3:0] k, m, m_n, rd_beat;
  logic            wbank, rbank, rbank_n;
  logic [1:0]      full, full_n;
  state_t          state, state_n;
  logic            wr_last, avail, emit, rd_done;

  assign lane[0] = fftIn0_up;
  assign lane[1] = fftIn0_down;
  assign lane[2] = fftIn1_up;
  assign lane[3] = fftIn1_down;

  assign wr_last = in_enable && (k == LAST);
  // A bank counts as available on the very edge that completes it, so beat 0
  // can be registered together with the final write (bypass below).
  assign avail   = full[rbank] || (wr_last && (wbank == rbank));

  always_comb begin
    for (int unsigned l = 0; l < 4; l++) waddr[l] = bitrev({k, 2'(l)});
  end

  // Storage needs no reset.
  always_ff @(posedge clk) begin
    if (in_enable) begin
      for (int unsigned l = 0; l < 4; l++) mem[wbank][waddr[l]] <= lane[l];
    end
  end

  // state tells where the next emitted beat comes from: IDLE launches beat 0
  // of rbank once available, READ continues beats 1..N/4-1. Returning to IDLE
  // after the last beat lets a bank completing on that next edge start with
  // no bubble.
  always_comb begin
    state_n = state;
    m_n     = m;
    rbank_n = rbank;
    rd_beat = m;
    emit    = 1'b0;
    rd_done = 1'b0;
    unique case (state)
      IDLE: begin
        rd_beat = '0;
        if (avail) begin
          emit    = 1'b1;
          m_n     = (LOGN-2)'(1);
          state_n = READ;
        end
      end
      READ: begin
        emit = 1'b1;
        if (m == LAST) begin
          rd_done = 1'b1;
          m_n     = '0;
          rbank_n = ~rbank;
          state_n = IDLE;
        end else begin
          m_n = m + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Read mux with write-through for samples landing in rbank this cycle.
  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      raddr[j]   = {rd_beat, 2'(j)};
      rd_data[j] = mem[rbank][raddr[j]];
      if (in_enable && (wbank == rbank)) begin
        for (int unsigned l = 0; l < 4; l++) begin
          if (waddr[l] == raddr[j]) rd_data[j] = lane[l];
        end
      end
    end
  end

  always_comb begin
    full_n = full;
    if (rd_done) full_n[rbank] = 1'b0;
    if (wr_last) full_n[wbank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k             <= '0;
      wbank         <= 1'b0;
      full          <= '0;
      state         <= IDLE;
      m             <= '0;
      rbank         <= 1'b0;
      binOut0       <= '0;
      binOut1       <= '0;
      binOut2       <= '0;
      binOut3       <= '0;
      o_enable      <= 1'b0;
      o_frame_start <= 1'b0;
      o_beat        <= '0;
    end else begin
      if (in_enable) begin
        k <= (k == LAST) ? '0 : k + 1'b1;
        if (k == LAST) wbank <= ~wbank;
      end
      full          <= full_n;
      state         <= state_n;
      m             <= m_n;
      rbank         <= rbank_n;
      o_enable      <= emit;
      o_frame_start <= emit && (rd_beat == '0);
      if (emit) begin
        binOut0 <= rd_data[0];
        binOut1 <= rd_data[1];
        binOut2 <= rd_data[2];
        binOut3 <= rd_data[3];
        o_beat  <= rd_beat;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
module tb_fft_out_reorder;

  localparam int NB    = 19;
  localparam int N     = 32;
  localparam int LOGN  = 5;
  localparam int W     = 2 * NB;
  localparam int BEATS = N / 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [W-1:0]    lanes [4];
  logic            in_enable = 1'b0;
  logic [W-1:0]    binOut0, binOut1, binOut2, binOut3;
  logic            o_enable, o_frame_start;
  logic [LOGN-3:0] o_beat;

  always #5 clk = ~clk;

  fft_out_reorder #(.NBITS_out(NB), .N(N), .LOGN(LOGN)) dut (
    .clk(clk), .rst(rst),
    .fftIn0_up(lanes[0]), .fftIn0_down(lanes[1]),
    .fftIn1_up(lanes[2]), .fftIn1_down(lanes[3]),
    .in_enable(in_enable),
    .binOut0(binOut0), .binOut1(binOut1), .binOut2(binOut2), .binOut3(binOut3),
    .o_enable(o_enable), .o_frame_start(o_frame_start), .o_beat(o_beat)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: a frame image indexed by bin, and a queue of output
  // beats that will appear one per clock once a frame is complete.
  typedef struct packed {
    logic [LOGN-3:0] beat;
    logic [W-1:0]    b0, b1, b2, b3;
  } beat_t;

  beat_t           q[$];
  logic [W-1:0]    frame [N];
  int              kcnt = 0;
  logic            exp_en = 1'b0, exp_fs = 1'b0;
  logic [LOGN-3:0] exp_beat = '0;
  logic [W-1:0]    exp_b [4] = '{default: '0};

  function automatic int brev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < LOGN; i++) if (a[i]) r |= (1 << (LOGN - 1 - i));
    return r;
  endfunction

  function automatic logic [W-1:0] mk(input int a);
    logic [NB-1:0] re, im;
    re = NB'(a);
    im = -re;
    return {re, im};
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    kcnt     = 0;
    exp_en   = 1'b0;
    exp_fs   = 1'b0;
    exp_beat = '0;
    for (int j = 0; j < 4; j++) exp_b[j] = '0;
  endtask

  task automatic model_edge();
    beat_t b;
    if (!rst) return;
    if (in_enable) begin
      for (int l = 0; l < 4; l++) frame[brev(4 * kcnt + l)] = lanes[l];
      kcnt++;
      if (kcnt == BEATS) begin
        for (int m = 0; m < BEATS; m++)
          q.push_back('{(LOGN-2)'(m), frame[4*m], frame[4*m+1], frame[4*m+2], frame[4*m+3]});
        kcnt = 0;
      end
    end
    if (q.size() > 0) begin
      b        = q.pop_front();
      exp_en   = 1'b1;
      exp_fs   = (b.beat == '0);
      exp_beat = b.beat;
      exp_b[0] = b.b0;
      exp_b[1] = b.b1;
      exp_b[2] = b.b2;
      exp_b[3] = b.b3;
    end else begin
      exp_en = 1'b0;
      exp_fs = 1'b0;
    end
  endtask

  task automatic compare();
    check("o_enable", 64'(o_enable), 64'(exp_en));
    check("o_frame_start", 64'(o_frame_start), 64'(exp_fs));
    check("o_beat", 64'(o_beat), 64'(exp_beat));
    check("binOut0", 64'(binOut0), 64'(exp_b[0]));
    check("binOut1", 64'(binOut1), 64'(exp_b[1]));
    check("binOut2", 64'(binOut2), 64'(exp_b[2]));
    check("binOut3", 64'(binOut3), 64'(exp_b[3]));
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic cycle(input logic en, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_enable = en;
    lanes[0]  = d0;
    lanes[1]  = d1;
    lanes[2]  = d2;
    lanes[3]  = d3;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd(), rnd(), rnd(), rnd());
  endtask

  task automatic ramp_frame();
    for (int k = 0; k < BEATS; k++)
      cycle(1'b1, mk(4*k), mk(4*k+1), mk(4*k+2), mk(4*k+3));
  endtask

  task automatic rand_frame();
    for (int k = 0; k < BEATS; k++) cycle(1'b1, rnd(), rnd(), rnd(), rnd());
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    #1;
    rst = 1'b0;
    #1;
    check("async o_enable", 64'(o_enable), 64'(0));
    check("async o_frame_start", 64'(o_frame_start), 64'(0));
    check("async o_beat", 64'(o_beat), 64'(0));
    check("async binOut0", 64'(binOut0), 64'(0));
    check("async binOut3", 64'(binOut3), 64'(0));
    model_reset();
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    for (int l = 0; l < 4; l++) lanes[l] = '0;
    model_reset();

    // Power-on reset
    idle(3);
    rst = 1'b1;
    idle(2);

    // Single frame, ramp data, no gaps
    ramp_frame();
    check("s1 beat0 bin1", 64'(binOut1), 64'(mk(16)));
    check("s1 beat0 bin2", 64'(binOut2), 64'(mk(8)));
    check("s1 beat0 bin3", 64'(binOut3), 64'(mk(24)));
    idle(10);

    // Back-to-back frames
    for (int f = 0; f < 3; f++) rand_frame();
    idle(10);

    // Input gaps with junk on invalid cycles
    for (int k = 0; k < BEATS; k++) begin
      cycle(1'b1, mk(4*k), mk(4*k+1), mk(4*k+2), mk(4*k+3));
      cycle(1'b0, rnd(), rnd(), rnd(), rnd());
    end
    idle(10);

    // Random gap pattern, bounded
    begin
      int valid = 0;
      for (int i = 0; i < 200 && valid < 2 * BEATS; i++) begin
        logic en;
        en = 1'($urandom_range(0, 1));
        cycle(en, rnd(), rnd(), rnd(), rnd());
        if (en) valid++;
      end
      check("random gap frames completed", 64'(valid), 64'(2 * BEATS));
    end
    idle(10);

    // Reset mid-frame
    for (int k = 0; k < 5; k++) cycle(1'b1, rnd(), rnd(), rnd(), rnd());
    async_reset();
    idle(2);
    ramp_frame();
    idle(10);

    // Reset mid-read at output beat 3
    rand_frame();
    idle(3);
    check("pre-reset beat", 64'(o_beat), 64'(3));
    async_reset();
    idle(12);
    rand_frame();
    idle(10);

    // Extreme values
    for (int k = 0; k < BEATS; k++)
      cycle(1'b1, {19'h3FFFF, 19'h40000}, {19'h3FFFF, 19'h40000},
            {19'h3FFFF, 19'h40000}, {19'h3FFFF, 19'h40000});
    check("extreme bin0", 64'(binOut0), 64'({19'h3FFFF, 19'h40000}));
    idle(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
